memory_responder: RTL and testbench
===================================

# memory_responder

Memory-side responder for the processor's memory interface. The control unit drives MOV, R/W, MAR and MDR and waits on MOC; this block is the RAM that answers. It latches each request, inserts a fixed number of wait states, performs a big-endian byte/halfword/word access, and raises MOC until the initiator drops MOV. It completes the phase-2 datapath alongside the control unit.

## Interface
Parameters:
- ADDR_BITS, 8, byte-address width; memory holds 2^ADDR_BITS bytes.
- WAIT_CYCLES, 2, clock edges between request capture and MOC; legal range 0–15.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- MOV  in  1  memory operation valid, from the control unit.
- RW  in  1  1 = read, 0 = write.
- SIZE  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- ADDR  in  32  byte address from MAR; only ADDR[ADDR_BITS-1:0] is used.
- DATA_IN  in  32  write data from MDR.
- DATA_OUT  out  32  read data, zero-extended for byte and halfword reads.
- MOC  out  1  memory operation complete.
- ERR  out  1  request rejected; valid while MOC=1.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - When MOV=1, latch RW, SIZE, ADDR mod 2^ADDR_BITS and DATA_IN.
  - If WAIT_CYCLES=0, go to DONE and perform the access on the same edge.
  - Otherwise load the counter with WAIT_CYCLES and go to BUSY.
- **BUSY**
  - If MOV=0: abort, go to IDLE, no write, no MOC.
  - Otherwise decrement the counter. On the edge where it reaches 0, perform the access and go to DONE.
  - Input changes while BUSY are ignored; only latched values are used.
- **DONE**
  - MOC=1.
  - When MOV=0, go to IDLE with MOC=0.
  - If MOV stays high, remain in DONE. No second access occurs.
- **Byte order:** big-endian. A word at A has mem[A]=bits 31:24, mem[A+1]=23:16, mem[A+2]=15:8, mem[A+3]=7:0. A halfword at A has mem[A]=15:8, mem[A+1]=7:0.
- **Reads**
  - Byte reads load DATA_OUT={24'b0, mem[A]}.
  - Halfword reads load DATA_OUT={16'b0, mem[A], mem[A+1]}.
  - DATA_OUT holds its value until the next successful read.
- **Writes**
  - Byte writes store DATA_IN[7:0]; halfword writes store DATA_IN[15:0].
  - Writes never change DATA_OUT.
- **Errors:** SIZE=11, a halfword with A[0]=1, or a word with A[1:0]≠00.
  - Sets ERR=1 in DONE.
  - No memory write and no DATA_OUT update.
  - MOC handshake proceeds normally.
- **Reset**
  - State IDLE, MOC=0, ERR=0, DATA_OUT=0, counter=0.
  - Memory contents are not cleared.
  - Reset during BUSY aborts with no write. Reset during DONE drops MOC.
  - RESET takes priority over every other condition.

## Timing
- The edge that samples MOV=1 in IDLE is edge 0.
- MOC is high after edge WAIT_CYCLES and low after the first edge that samples MOV=0 in DONE.
- DATA_OUT and ERR are registered. They become valid on the same edge MOC rises.
- Back-to-back requests: after MOC falls, the earliest new capture is the next edge with MOV=1. Minimum request period is WAIT_CYCLES+2 edges.
- Aligned accesses never wrap. The top aligned word is at 2^ADDR_BITS-4.

## Structure
- Shared package `mem_if_pkg`:
  - SIZE encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encodings S_IDLE, S_BUSY, S_DONE.
  - Constant RW_READ=1'b1.
- One sub-module, `mem_byte_array`: the 2^ADDR_BITS×8 storage with big-endian lane steering. It takes a write enable, size and address, and returns a 32-bit read word.
- The FSM, counter and alignment check live in `memory_responder`.

## Test plan
- Word write, then read, WAIT_CYCLES=2: write 0x11223344 at 0x04, then read 0x04 → DATA_OUT=0x11223344. MOC rises after edge 2 of each request. Byte read of 0x04 → 0x00000011; byte read of 0x07 → 0x00000044.
- Halfword write 0xBEEF at 0x06 over the word above, then word read 0x04 → 0x1122BEEF. Halfword read 0x06 → 0x0000BEEF.
- Misaligned word read at 0x05 → MOC=1, ERR=1, DATA_OUT unchanged. A following word read at 0x04 returns 0x1122BEEF with ERR=0.
- MOV deasserted during BUSY on a write of 0xFFFFFFFF at 0x04 → MOC never rises, and a later read returns 0x1122BEEF.
- MOV held high 5 edges in DONE → a single access, MOC stays 1. With WAIT_CYCLES=0 the same request's MOC rises after edge 0.
- RESET asserted during BUSY → MOC=0, ERR=0, DATA_OUT=0 after the edge, and memory is unmodified.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared encodings for the processor memory interface.
// Used by the memory responder and its byte array.
package mem_if_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic RW_READ = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   function automatic logic bad_req(
      input logic [1:0] size,
      input logic [1:0] lo
   );
      bad_req = (size == 2'b11)
             || (size == SZ_HALF && lo[0])
             || (size == SZ_WORD && lo != 2'b00);
   endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with big-endian lane steering.
// Reads are combinational and zero-extended by access size.
module mem_byte_array
   import mem_if_pkg::*;
#(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [1:0]           size,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [7:0] mem [2**ADDR_BITS];

   logic [ADDR_BITS-1:0] a1;
   logic [ADDR_BITS-1:0] a2;
   logic [ADDR_BITS-1:0] a3;

   assign a1 = addr + ADDR_BITS'(1);
   assign a2 = addr + ADDR_BITS'(2);
   assign a3 = addr + ADDR_BITS'(3);

   always_comb begin
      rdata = 32'h0;
      unique case (size)
         SZ_BYTE: rdata = {24'h0, mem[addr]};
         SZ_HALF: rdata = {16'h0, mem[addr], mem[a1]};
         SZ_WORD: rdata = {mem[addr], mem[a1], mem[a2], mem[a3]};
         default: rdata = 32'h0;
      endcase
   end

   // No reset: contents survive RESET.
   always_ff @(posedge clk) begin
      if (we) begin
         unique case (size)
            SZ_BYTE: mem[addr] <= wdata[7:0];
            SZ_HALF: begin
               mem[addr] <= wdata[15:8];
               mem[a1]   <= wdata[7:0];
            end
            SZ_WORD: begin
               mem[addr] <= wdata[31:24];
               mem[a1]   <= wdata[23:16];
               mem[a2]   <= wdata[15:8];
               mem[a3]   <= wdata[7:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/memory_responder.sv
// RAM side of the MOV/MOC handshake: latch, wait, access,
// then hold MOC until the initiator drops MOV.
module memory_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_BITS   = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MOV,
   input  logic        RW,
   input  logic [1:0]  SIZE,
   input  logic [31:0] ADDR,
   input  logic [31:0] DATA_IN,
   output logic [31:0] DATA_OUT,
   output logic        MOC,
   output logic        ERR
);

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 rw_q, rw_d;
   logic [1:0]           size_q, size_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          dout_q, dout_d;
   logic                 err_q, err_d;

   logic                 req_rw;
   logic [1:0]           req_size;
   logic [ADDR_BITS-1:0] req_addr;
   logic [31:0]          req_wdata;
   logic                 access;
   logic                 bad;
   logic                 we;
   logic [31:0]          rdata;

   // A zero-wait access happens on the capture edge, so use live inputs.
   always_comb begin
      if (state_q == S_IDLE) begin
         req_rw    = RW;
         req_size  = SIZE;
         req_addr  = ADDR[ADDR_BITS-1:0];
         req_wdata = DATA_IN;
      end else begin
         req_rw    = rw_q;
         req_size  = size_q;
         req_addr  = addr_q;
         req_wdata = wdata_q;
      end
   end

   assign bad = bad_req(req_size, req_addr[1:0]);
   assign we  = access && !bad && (req_rw != RW_READ);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      err_d   = err_q;
      access  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (MOV) begin
               rw_d    = RW;
               size_d  = SIZE;
               addr_d  = ADDR[ADDR_BITS-1:0];
               wdata_d = DATA_IN;
               if (WAIT_CYCLES == 0) begin
                  access  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  cnt_d   = 4'(WAIT_CYCLES);
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (!MOV) begin
               cnt_d   = 4'h0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'h1;
               if (cnt_q == 4'h1) begin
                  access  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!MOV) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (access) begin
         err_d = bad;
         if (!bad && req_rw == RW_READ) dout_d = rdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'h0;
         rw_q    <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         dout_q  <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         err_q   <= err_d;
      end
   end

   mem_byte_array #(
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clk   (CLK),
      .we    (we && !RESET),
      .size  (req_size),
      .addr  (req_addr),
      .wdata (req_wdata),
      .rdata (rdata)
   );

   assign DATA_OUT = dout_q;
   assign MOC      = (state_q == S_DONE);
   assign ERR      = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_memory_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mov = 1'b0;
   logic        mov0 = 1'b0;
   logic        rw = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = 32'h0;
   logic [31:0] din = 32'h0;
   logic [31:0] dout, dout0;
   logic        moc, moc0, err, err0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   memory_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
      .CLK(clk), .RESET(rst), .MOV(mov), .RW(rw), .SIZE(size),
      .ADDR(addr), .DATA_IN(din), .DATA_OUT(dout), .MOC(moc), .ERR(err)
   );

   memory_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
      .CLK(clk), .RESET(rst), .MOV(mov0), .RW(rw), .SIZE(size),
      .ADDR(addr), .DATA_IN(din), .DATA_OUT(dout0), .MOC(moc0), .ERR(err0)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a request, leave MOV held in DONE for 'hold' edges, then release.
   task automatic req(input bit sel, input logic r, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      input int hold, output int lat);
      rw = r; size = s; addr = a; din = d;
      if (sel) mov0 = 1'b1; else mov = 1'b1;
      tick();
      lat = 0;
      while (!(sel ? moc0 : moc) && lat < 20) begin
         tick();
         lat++;
      end
      for (int i = 0; i < hold; i++) begin
         addr = 32'h0; din = 32'hA5A5A5A5;
         tick();
         chk("moc_hold", {31'h0, sel ? moc0 : moc}, 32'h1);
      end
      mov = 1'b0; mov0 = 1'b0;
      tick();
      chk("moc_fall", {31'h0, sel ? moc0 : moc}, 32'h0);
   endtask

   int lat;

   initial begin
      rst = 1'b1;
      tick(); tick();
      chk("rst_moc", {31'h0, moc}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_dout", dout, 32'h0);
      rst = 1'b0;
      tick();

      req(0, 1'b0, 2'b10, 32'h04, 32'h11223344, 0, lat);
      chk("wr_lat", lat, 2);
      chk("wr_dout", dout, 32'h0);
      req(0, 1'b1, 2'b10, 32'h04, 32'h0, 0, lat);
      chk("rd_lat", lat, 2);
      chk("rd_word", dout, 32'h11223344);
      chk("rd_err", {31'h0, err}, 32'h0);
      req(0, 1'b1, 2'b00, 32'h04, 32'h0, 0, lat);
      chk("rd_b4", dout, 32'h00000011);
      req(0, 1'b1, 2'b00, 32'h07, 32'h0, 0, lat);
      chk("rd_b7", dout, 32'h00000044);

      req(0, 1'b0, 2'b01, 32'h06, 32'h0000BEEF, 0, lat);
      req(0, 1'b1, 2'b10, 32'h04, 32'h0, 0, lat);
      chk("rd_mix", dout, 32'h1122BEEF);
      req(0, 1'b1, 2'b01, 32'h06, 32'h0, 0, lat);
      chk("rd_half", dout, 32'h0000BEEF);

      req(0, 1'b1, 2'b10, 32'h05, 32'h0, 0, lat);
      chk("mis_lat", lat, 2);
      chk("mis_err", {31'h0, err}, 32'h1);
      chk("mis_dout", dout, 32'h0000BEEF);
      req(0, 1'b1, 2'b10, 32'h04, 32'h0, 0, lat);
      chk("after_mis", dout, 32'h1122BEEF);
      chk("after_err", {31'h0, err}, 32'h0);
      req(0, 1'b0, 2'b01, 32'h07, 32'h00000000, 0, lat);
      chk("half_mis", {31'h0, err}, 32'h1);
      req(0, 1'b0, 2'b11, 32'h04, 32'h00000000, 0, lat);
      chk("rsv_err", {31'h0, err}, 32'h1);
      req(0, 1'b1, 2'b10, 32'h04, 32'h0, 0, lat);
      chk("no_err_wr", dout, 32'h1122BEEF);

      // Abort in BUSY: MOV drops after edge 1.
      rw = 1'b0; size = 2'b10; addr = 32'h04; din = 32'hFFFFFFFF;
      mov = 1'b1;
      tick(); tick();
      mov = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("abort_moc", {31'h0, moc}, 32'h0);
      end
      req(0, 1'b1, 2'b10, 32'h04, 32'h0, 0, lat);
      chk("abort_mem", dout, 32'h1122BEEF);

      // Upper address bits ignored; top aligned word.
      req(0, 1'b0, 2'b10, 32'hABCD00FC, 32'h0A0B0C0D, 0, lat);
      req(0, 1'b1, 2'b10, 32'h000000FC, 32'h0, 0, lat);
      chk("top_word", dout, 32'h0A0B0C0D);

      // Hold MOV in DONE; inputs changed meanwhile must not matter.
      req(0, 1'b0, 2'b00, 32'h05, 32'h00000077, 5, lat);
      req(0, 1'b1, 2'b10, 32'h04, 32'h0, 0, lat);
      chk("hold_once", dout, 32'h1177BEEF);
      req(0, 1'b1, 2'b10, 32'h00, 32'h0, 0, lat);
      chk("hold_addr0", {31'h0, err}, 32'h0);

      req(1, 1'b0, 2'b10, 32'h10, 32'hCAFEF00D, 0, lat);
      chk("w0_wr_lat", lat, 0);
      req(1, 1'b1, 2'b10, 32'h10, 32'h0, 0, lat);
      chk("w0_rd_lat", lat, 0);
      chk("w0_rd", dout0, 32'hCAFEF00D);

      // Reset while DONE with ERR set.
      rw = 1'b1; size = 2'b10; addr = 32'h06; mov = 1'b1;
      tick(); tick(); tick();
      chk("pre_err", {31'h0, err}, 32'h1);
      rst = 1'b1;
      tick();
      chk("rdone_moc", {31'h0, moc}, 32'h0);
      chk("rdone_err", {31'h0, err}, 32'h0);
      mov = 1'b0; rst = 1'b0;
      tick();

      req(0, 1'b1, 2'b10, 32'h04, 32'h0, 0, lat);
      rw = 1'b0; size = 2'b10; addr = 32'h04; din = 32'hDEADBEEF;
      mov = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      chk("rbusy_moc", {31'h0, moc}, 32'h0);
      chk("rbusy_err", {31'h0, err}, 32'h0);
      chk("rbusy_dout", dout, 32'h0);
      mov = 1'b0; rst = 1'b0;
      tick(); tick();
      chk("rbusy_idle", {31'h0, moc}, 32'h0);
      req(0, 1'b1, 2'b10, 32'h04, 32'h0, 0, lat);
      chk("rbusy_mem", dout, 32'h1177BEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
